// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the sign-magnitude approximate multipliers.
package approx_mult_pkg;

    // Upper bounds for the helper functions; callers slice the low bits they need.
    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_W2 = 2 * MAX_W;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIN,
        DONE
    } state_t;

    // Top min(rec, width2) bits set within a width2-bit word (rest of MAX_W2 is zero).
    function automatic logic [MAX_W2-1:0] rec_mask(input int unsigned width2,
                                                   input int unsigned rec);
        logic [MAX_W2-1:0] m;
        int unsigned       r;
        r = (rec > width2) ? width2 : rec;
        m = '0;
        for (int unsigned k = 0; k < MAX_W2; k++) begin
            if ((k < width2) && (k + r >= width2)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    // Returns {sign, magnitude}; the magnitude occupies the low 'width' bits.
    // The most negative value maps to 2^(width-1), which still fits in 'width' bits.
    function automatic logic [MAX_W:0] abs_sm(input logic [MAX_W-1:0] value,
                                              input int unsigned       width,
                                              input logic              is_signed);
        logic [MAX_W-1:0] keep;
        logic [MAX_W-1:0] v;
        logic [MAX_W-1:0] mag;
        logic             s;
        keep = '0;
        for (int unsigned k = 0; k < MAX_W; k++) begin
            if (k < width) begin
                keep[k] = 1'b1;
            end
        end
        v = value & keep;
        s = 1'b0;
        for (int unsigned k = 0; k < MAX_W; k++) begin
            if (k + 1 == width) begin
                s = is_signed & v[k];
            end
        end
        mag = s ? ((-v) & keep) : v;
        return {s, mag};
    endfunction

endpackage

// File: rtl/approx_acc_adder.sv
// OR-based approximate accumulator step: carries are restored only where mask is set.
module approx_acc_adder #(
    parameter int unsigned W2 = 32
) (
    input  logic [W2-1:0] acc,
    input  logic [W2-1:0] pp,
    input  logic [W2-1:0] mask,
    output logic [W2-1:0] sum
);

    // (a|b) + (a&b) == a+b, so masking the AND term limits where the error is recovered.
    assign sum = (acc | pp) + ((acc & pp) & mask);

endmodule

// File: rtl/sm_approx_mult_seq.sv
// Sequential sign-magnitude shift-add multiplier with configurable error recovery.
module sm_approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned REC_W = $clog2(2 * WIDTH + 1)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               sgn,
    input  logic [REC_W-1:0]   rec_bits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic               r_sa;
    logic               r_sb;
    logic [W2-1:0]      r_acc;
    logic [W2-1:0]      r_mask;
    logic [W2-1:0]      r_p;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_W:0]     w_x_abs;
    logic [MAX_W:0]     w_y_abs;
    logic [MAX_W2-1:0]  w_mask_full;
    logic [W2-1:0]      w_pp;
    logic [W2-1:0]      w_sum;
    logic               w_last;
    logic               w_unused_bits;

    // Operand conversion and mask generation evaluated on the live inputs at accept time.
    always_comb begin
        w_x_abs     = abs_sm(MAX_W'(x), WIDTH, sgn);
        w_y_abs     = abs_sm(MAX_W'(y), WIDTH, sgn);
        w_mask_full = rec_mask(W2, 32'(rec_bits));
        w_pp        = r_mb[r_cnt] ? (W2'(r_ma) << r_cnt) : '0;
        w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    end

    assign w_unused_bits = ^{w_x_abs[MAX_W-1:WIDTH], w_y_abs[MAX_W-1:WIDTH],
                             w_mask_full[MAX_W2-1:W2]};

    approx_acc_adder #(
        .W2 (W2)
    ) u_adder (
        .acc  (r_acc),
        .pp   (w_pp),
        .mask (r_mask),
        .sum  (w_sum)
    );

    // Control FSM and datapath; handshake outputs are registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_acc       <= '0;
            r_mask      <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ma       <= w_x_abs[WIDTH-1:0];
                        r_mb       <= w_y_abs[WIDTH-1:0];
                        r_sa       <= w_x_abs[MAX_W];
                        r_sb       <= w_y_abs[MAX_W];
                        r_mask     <= w_mask_full[W2-1:0];
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    // Negating a zero magnitude yields zero, so no negative zero can appear.
                    r_p         <= (r_sa ^ r_sb) ? -r_acc : r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;

endmodule
